// File: rtl/stream_pkg.sv
// Shared types and helpers for the valid/ready stream blocks.
package stream_pkg;

    // Arbiter packet state: IDLE picks a new winner, LOCKED holds it to the last beat.
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    // Modulo-n increment. Wraps n-1 back to 0, so non-power-of-two counts never overflow.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request at or after ptr,
// wrapping from P_NUM_IN-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int P_NUM_IN = 4,
    localparam int P_IDX_WIDTH = $clog2(P_NUM_IN)
) (
    input  logic [P_NUM_IN-1:0]    req,
    input  logic [P_IDX_WIDTH-1:0] ptr,
    output logic                   any,
    output logic [P_IDX_WIDTH-1:0] idx
);

    // Scan from the farthest candidate back towards ptr so the nearest one wins.
    always_comb begin
        int cand;
        any  = |req;
        idx  = '0;
        cand = 0;
        for (int k = P_NUM_IN - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= P_NUM_IN) begin
                cand = cand - P_NUM_IN;
            end
            if (req[P_IDX_WIDTH'(cand)]) begin
                idx = P_IDX_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_arb_vr.sv
// Packet-aware round-robin arbiter for valid/ready streams with a registered output.
//
// Handshake: a beat moves across an interface on a rising clk edge where both
// valid and ready are 1. valid and its payload are held by the source until
// accepted; ready may depend combinationally on valid only on the input side.
module rr_arb_vr
    import stream_pkg::*;
#(
    parameter int P_NUM_IN     = 4,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_IDX_WIDTH  = $clog2(P_NUM_IN)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [P_NUM_IN-1:0]              valid_in,
    input  logic [P_NUM_IN*P_DATA_WIDTH-1:0] data_in,
    input  logic [P_NUM_IN-1:0]              last_in,
    output logic [P_NUM_IN-1:0]              ready_in,
    output logic                             valid_out,
    output logic [P_DATA_WIDTH-1:0]          data_out,
    output logic                             last_out,
    output logic [P_IDX_WIDTH-1:0]           src_out,
    input  logic                             ready_out
);

    arb_state_e             state;
    arb_state_e             state_next;
    logic [P_IDX_WIDTH-1:0] rr_ptr;
    logic [P_IDX_WIDTH-1:0] rr_ptr_next;
    logic [P_IDX_WIDTH-1:0] lock_idx;
    logic [P_IDX_WIDTH-1:0] lock_idx_next;

    logic                    pick_any;
    logic [P_IDX_WIDTH-1:0]  pick_idx;
    logic                    have_grant;
    logic [P_IDX_WIDTH-1:0]  grant_idx;
    logic                    can_accept;
    logic                    xfer;
    logic [P_DATA_WIDTH-1:0] sel_data;
    logic                    sel_last;

    rr_pick #(.P_NUM_IN(P_NUM_IN)) u_pick (
        .req (valid_in),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign can_accept = !valid_out || ready_out;
    assign have_grant = (state == ARB_LOCKED) ? 1'b1 : pick_any;
    assign grant_idx  = (state == ARB_LOCKED) ? lock_idx : pick_idx;
    assign xfer       = |(valid_in & ready_in);

    // One-hot ready towards the granted input; forced low while reset is held.
    always_comb begin
        ready_in = '0;
        if (!rst && can_accept && have_grant) begin
            ready_in[grant_idx] = 1'b1;
        end
    end

    // Payload mux for the granted input.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < P_NUM_IN; i++) begin
            if (grant_idx == P_IDX_WIDTH'(i)) begin
                sel_data = data_in[i*P_DATA_WIDTH +: P_DATA_WIDTH];
                sel_last = last_in[i];
            end
        end
    end

    // Next-state logic: lock on a non-last beat, release and advance pointer on last.
    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        lock_idx_next = lock_idx;
        case (state)
            ARB_IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        rr_ptr_next = P_IDX_WIDTH'(next_idx(32'(grant_idx), 32'(P_NUM_IN)));
                    end else begin
                        state_next    = ARB_LOCKED;
                        lock_idx_next = grant_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                if (xfer && sel_last) begin
                    state_next  = ARB_IDLE;
                    rr_ptr_next = P_IDX_WIDTH'(next_idx(32'(lock_idx), 32'(P_NUM_IN)));
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            lock_idx <= lock_idx_next;
        end
    end

    // Output register: reload on transfer (no bubble), clear valid once drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
            src_out   <= '0;
        end else if (xfer) begin
            valid_out <= 1'b1;
            data_out  <= sel_data;
            last_out  <= sel_last;
            src_out   <= grant_idx;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_vr.sv
// Bench for rr_arb_vr (N=4, W=32): table-driven vectors with a beat scoreboard
// plus hand sequences for stall, wrap and reset-in-packet cases.
module tb_rr_arb_vr;
    import stream_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int BW = IW + 1 + W;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid_in;
    logic [N*W-1:0]  data_in;
    logic [N-1:0]    last_in;
    logic [N-1:0]    ready_in;
    logic            valid_out;
    logic [W-1:0]    data_out;
    logic            last_out;
    logic [IW-1:0]   src_out;
    logic            ready_out;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         rdy;
        logic [N-1:0] exp_ready;
    } vec_t;

    vec_t          tbl[$];
    logic [BW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    rr_arb_vr #(.P_NUM_IN(N), .P_DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .last_out  (last_out),
        .src_out   (src_out),
        .ready_out (ready_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                       input logic [N-1:0] e);
        vec_t t;
        t.valid = v; t.last = l; t.rdy = r; t.exp_ready = e;
        tbl.push_back(t);
    endtask

    // driver: drive one cycle of stimulus, push expected beat, check at negedge
    task automatic apply(input vec_t v);
        logic [BW-1:0] beat;
        valid_in  = v.valid;
        last_in   = v.last;
        ready_out = v.rdy;
        for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom;
        for (int i = 0; i < N; i++) begin
            if (v.exp_ready[i] && v.valid[i])
                exp_q.push_back({IW'(i), v.last[i], data_in[i*W +: W]});
        end
        @(negedge clk);
        check("ready_in", 64'(ready_in), 64'(v.exp_ready));
        if (valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got src %0d data %0h, expected none", src_out, data_out);
            end else begin
                beat = exp_q.pop_front();
                check("out_beat", 64'({src_out, last_out, data_out}), 64'(beat));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        // reset state, including valids present while in reset
        rst = 1'b1; valid_in = 4'hF; last_in = 4'hF; data_in = '0; ready_out = 1'b1;
        #12;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_last_out", 64'(last_out), 64'd0);
        check("rst_src_out", 64'(src_out), 64'd0);
        check("rst_state", 64'(dut.state), 64'(ARB_IDLE));
        check("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; valid_in = '0;

        // round robin across all four single-beat inputs: 0,1,2,3,0,1,2
        add(4'hF, 4'hF, 1, 4'b0001); add(4'hF, 4'hF, 1, 4'b0010);
        add(4'hF, 4'hF, 1, 4'b0100); add(4'hF, 4'hF, 1, 4'b1000);
        add(4'hF, 4'hF, 1, 4'b0001); add(4'hF, 4'hF, 1, 4'b0010);
        add(4'hF, 4'hF, 1, 4'b0100);
        // 3-beat packet on input 1 while input 2 waits (incl. one source-side stall)
        add(4'b0110, 4'b0000, 1, 4'b0010); add(4'b0110, 4'b0000, 1, 4'b0010);
        add(4'b0100, 4'b0000, 1, 4'b0010); add(4'b0110, 4'b0010, 1, 4'b0010);
        add(4'b0100, 4'b0100, 1, 4'b0100);
        run_tbl();

        // output back-pressure for 3 cycles with input 2's beat pending
        for (int i = 0; i < 3; i++) begin
            add(4'b0001, 4'b0001, 0, 4'b0000);
            run_tbl();
            check("stall_valid", 64'(valid_out), 64'd1);
            check("stall_hold", 64'({src_out, last_out, data_out}), 64'(exp_q[0]));
        end
        // release: drain and refill back-to-back, no bubble
        for (int i = 0; i < 2; i++) begin
            add(4'b0001, 4'b0001, 1, 4'b0001);
            run_tbl();
            check("no_bubble", 64'(valid_out), 64'd1);
        end

        // pointer wrap: walk to input 3, then 0 beats 3
        add(4'b0010, 4'b0010, 1, 4'b0010); add(4'b0100, 4'b0100, 1, 4'b0100);
        run_tbl();
        check("ptr_at_3", 64'(dut.rr_ptr), 64'd3);
        add(4'b1000, 4'b1000, 1, 4'b1000);
        run_tbl();
        check("ptr_wrap", 64'(dut.rr_ptr), 64'd0);
        add(4'b1001, 4'b1001, 1, 4'b0001); add(4'b1001, 4'b1001, 1, 4'b1000);
        run_tbl();

        // reset while input 2 is mid-packet
        add(4'b0100, 4'b0000, 1, 4'b0100); add(4'b0100, 4'b0000, 1, 4'b0100);
        run_tbl();
        check("locked", 64'(dut.state), 64'(ARB_LOCKED));
        check("pre_rst_valid", 64'(valid_out), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(valid_out), 64'd0);
        check("async_rst_ready", 64'(ready_in), 64'd0);
        check("async_rst_state", 64'(dut.state), 64'(ARB_IDLE));
        check("async_rst_ptr", 64'(dut.rr_ptr), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        add(4'b0101, 4'b0101, 1, 4'b0001);
        add(4'b0000, 4'b0000, 1, 4'b0000); add(4'b0000, 4'b0000, 1, 4'b0000);
        run_tbl();
        check("drained_valid", 64'(valid_out), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arb_vr.md
Name: rr_arb_vr

Overview:
- N-input round-robin arbiter for valid/ready streams with packet framing (last).
- Multiplexes N requesters onto one shared output stream.
- Holds the grant from the first accepted beat of a packet to its last beat, so packets are never interleaved.
- Output is registered (forward-pipelined). Pair with rev_pipe_vr downstream when the ready path also needs breaking.

Parameters:
- P_NUM_IN, 4, number of input streams; must be >= 2.
- P_DATA_WIDTH, 32, data bits per beat.
- P_IDX_WIDTH, $clog2(P_NUM_IN), width of the source index; derived, do not override.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Asynchronous, active-high; all state is cleared immediately on assertion.
- valid_in  input  P_NUM_IN  per-input valid.
- data_in  input  P_NUM_IN*P_DATA_WIDTH  per-input data; input i occupies bits [i*W +: W].
- last_in  input  P_NUM_IN  per-input end-of-packet flag.
- ready_in  output  P_NUM_IN  per-input ready; at most one bit is set at any time.
- valid_out  output  1  output valid (registered).
- data_out  output  P_DATA_WIDTH  output data (registered).
- last_out  output  1  output end-of-packet flag (registered).
- src_out  output  P_IDX_WIDTH  index of the input that supplied the current output beat (registered).
- ready_out  input  1  downstream ready.

Behaviour:
- Reset values: valid_out=0, data_out=0, last_out=0, src_out=0, state=IDLE, rr_ptr=0. ready_in is combinational and is 0 while in reset.
- Output acceptance: can_accept = !valid_out || ready_out.
- Input ready: ready_in[i] = can_accept && have_grant && (i == grant_idx).
- Input transfer: a transfer from input g occurs when valid_in[g] && ready_in[g]. Latency from input transfer to valid_out is 1 cycle. Throughput is 1 beat/cycle with ready_out held at 1.
- Output register update:
  - On an input transfer: valid_out<=1, data_out<=data_in[g], last_out<=last_in[g], src_out<=g.
  - Else if ready_out: valid_out<=0, and data/last/src hold.
  - Else: all output registers hold.
- State machine, IDLE:
  - have_grant = |valid_in.
  - grant_idx = first i with valid_in[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping N-1 -> 0.
  - The grant may move between cycles before any beat is accepted. This is legal, since no transfer has occurred.
  - Transfer with last=1 (single-beat packet): stay in IDLE; rr_ptr <= (g+1) mod N.
  - Transfer with last=0: go to LOCKED; lock_idx <= g.
- State machine, LOCKED:
  - have_grant=1 and grant_idx=lock_idx, regardless of other valids.
  - All other ready_in bits are 0.
  - Transfer with last=1: go to IDLE; rr_ptr <= (lock_idx+1) mod N.
  - Stall (valid_in[lock_idx]=0 or can_accept=0): hold LOCKED.
- Wrap-around: when rr_ptr is N-1, the next pointer value is 0. Pointer arithmetic is modulo P_NUM_IN, so a non-power-of-two N must not index past N-1.
- Simultaneous events: when ready_out=1, valid_out=1 and a new input transfer occur in the same cycle, the register reloads and valid_out stays 1, with no bubble.
- Reset mid-packet: the lock is dropped and the packet is truncated at the output. Upstream sources must reset together with this block.
- ready_in has a combinational path from ready_out and valid_in (IDLE only). valid_out/data_out have no combinational path from inputs.

Decomposition:
- Shared package stream_pkg contains:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  - function next_idx(idx, n), the modulo increment.
- Sub-module rr_pick: combinational rotating priority encoder.
  - Parameter: P_NUM_IN.
  - Inputs: req, ptr.
  - Outputs: any, idx.
  - Reusable by future non-packet arbiters.

Test Plan:
- Reset, N=4, no valids -> valid_out=0, ready_in=4'b0000. Assert rst asynchronously mid-cycle -> valid_out drops without waiting for a clk edge.
- All 4 inputs valid with single-beat packets (last=1), ready_out=1 -> src_out sequence 0,1,2,3,0,1 on consecutive cycles; one beat per cycle.
- Input 1 sends 3-beat packet (A1,A2,A3, last on A3) while input 2 is continuously valid -> outputs A1,A2,A3 then input 2's beat; ready_in[2]=0 throughout the packet.
- ready_out held 0 for 3 cycles with an output beat pending -> valid_out stays 1, data_out stable, ready_in all 0; release -> beat drains and the next beat follows with no bubble.
- Only input 3 valid, rr_ptr=3, single beat -> rr_ptr wraps to 0; then inputs 0 and 3 valid -> input 0 granted first.
- Reset asserted in LOCKED (input 2 mid-packet) -> state IDLE, rr_ptr=0, valid_out=0; after release with inputs 0 and 2 valid -> input 0 granted.
